// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between instruction
// fetch (IF) and the M-stage data port (DM). One transaction in flight at a
// time: IDLE arbitrates and captures, REQ drives the memory handshake, and
// WAIT routes the response back to its owner. Killed fetches are consumed
// silently.
// Optional feature: define MEM_TIMEOUT_EN to build a watchdog that aborts a
// transaction after TIMEOUT_CYC cycles in REQ+WAIT. It pulses err_o and
// returns 32'hDEAD_BEEF to the owner.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_kill_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef enum logic {OWNER_IF, OWNER_DM} owner_e;

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
  logic               killed_q, killed_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;

  logic               timeout;
  logic               resp_fire;
  logic [31:0]        resp_data;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  assign timeout = (state_q != IDLE) && (to_cnt_q == ToW'(TIMEOUT_CYC - 1));

  // Watchdog count: zero in IDLE so it starts at 0 on entering REQ, then counts every REQ/WAIT cycle
  always_comb begin
    to_cnt_d = '0;
    if (state_q != IDLE && !timeout) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Watchdog count register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // Without the watchdog a transaction waits forever; TIMEOUT_CYC is kept referenced so both builds share one parameter list
  localparam bit TimeoutCfg = (TIMEOUT_CYC != 0);
  assign timeout = 1'b0 & TimeoutCfg;
`endif

  assign busy_o = (state_q != IDLE);

  // Arbitration, request capture, memory handshake and response routing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    killed_d     = killed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    be_d         = be_q;
    resp_fire    = 1'b0;
    resp_data    = mem_rdata_i;
    if_gnt_o     = 1'b0;
    dm_gnt_o     = 1'b0;
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    dm_rvalid_o  = 1'b0;
    dm_rdata_o   = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    err_o        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Grants are held off while reset is asserted so every output stays 0
        if (rst_n_i && if_req_i && (!dm_req_i || starve_cnt_q == StarveMax)) begin
          if_gnt_o     = 1'b1;
          owner_d      = OWNER_IF;
          addr_d       = if_addr_i;
          we_d         = 1'b0;
          be_d         = 4'hF;
          wdata_d      = '0;
          starve_cnt_d = '0;
          state_d      = REQ;
        end else if (rst_n_i && dm_req_i) begin
          dm_gnt_o = 1'b1;
          owner_d  = OWNER_DM;
          addr_d   = dm_addr_i;
          we_d     = dm_we_i;
          be_d     = dm_be_i;
          wdata_d  = dm_wdata_i;
          if (!if_req_i) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != StarveMax) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_be_o    = be_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (owner_q == OWNER_IF && if_kill_i) begin
          killed_d = 1'b1;
        end
        if (timeout) begin
          err_o     = 1'b1;
          resp_fire = 1'b1;
          resp_data = 32'hDEAD_BEEF;
          state_d   = IDLE;
        end else if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (owner_q == OWNER_IF && if_kill_i) begin
          killed_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          resp_fire = 1'b1;
          state_d   = IDLE;
        end else if (timeout) begin
          err_o     = 1'b1;
          resp_fire = 1'b1;
          resp_data = 32'hDEAD_BEEF;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (resp_fire) begin
      if (owner_q == OWNER_DM) begin
        dm_rvalid_o = 1'b1;
        dm_rdata_o  = resp_data;
      end else if (!killed_q && !if_kill_i) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = resp_data;
      end
    end

    if (state_d == IDLE) begin
      killed_d = 1'b0;
    end
  end

  // State, owner, starvation count, kill flag and captured request
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_IF;
      starve_cnt_q <= '0;
      killed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      killed_q     <= killed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      be_q         <= be_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_MAX  = 4;
  localparam int unsigned TIMEOUT_CYC = 8;

  localparam logic        N   = 1'b0;
  localparam logic        Y   = 1'b1;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [3:0]  B0  = 4'h0;
  localparam logic [3:0]  BF  = 4'hF;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        x_if_gnt;
    logic        x_if_rvalid;
    logic [31:0] x_if_rdata;
    logic        x_dm_gnt;
    logic        x_dm_rvalid;
    logic [31:0] x_dm_rdata;
    logic        x_mem_req;
    logic        x_mem_we;
    logic [3:0]  x_mem_be;
    logic [31:0] x_mem_addr;
    logic [31:0] x_mem_wdata;
    logic        x_busy;
    logic        x_err;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        if_req_i, if_kill_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        busy_o, err_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  always #5 clk_i = ~clk_i;

  function automatic vec_t zeroVec();
    vec_t z;
    z = '{default: '0};
    return z;
  endfunction

  task automatic applyStimulus(input vec_t v);
    if_req_i     = v.if_req;
    if_addr_i    = v.if_addr;
    if_kill_i    = v.if_kill;
    dm_req_i     = v.dm_req;
    dm_we_i      = v.dm_we;
    dm_be_i      = v.dm_be;
    dm_addr_i    = v.dm_addr;
    dm_wdata_i   = v.dm_wdata;
    mem_gnt_i    = v.mem_gnt;
    mem_rvalid_i = v.mem_rvalid;
    mem_rdata_i  = v.mem_rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkVec(input vec_t v, input string tag);
    checkOutput({tag, ".if_gnt"},    32'(if_gnt_o),    32'(v.x_if_gnt));
    checkOutput({tag, ".if_rvalid"}, 32'(if_rvalid_o), 32'(v.x_if_rvalid));
    checkOutput({tag, ".if_rdata"},  if_rdata_o,       v.x_if_rdata);
    checkOutput({tag, ".dm_gnt"},    32'(dm_gnt_o),    32'(v.x_dm_gnt));
    checkOutput({tag, ".dm_rvalid"}, 32'(dm_rvalid_o), 32'(v.x_dm_rvalid));
    checkOutput({tag, ".dm_rdata"},  dm_rdata_o,       v.x_dm_rdata);
    checkOutput({tag, ".mem_req"},   32'(mem_req_o),   32'(v.x_mem_req));
    checkOutput({tag, ".mem_we"},    32'(mem_we_o),    32'(v.x_mem_we));
    checkOutput({tag, ".mem_be"},    32'(mem_be_o),    32'(v.x_mem_be));
    checkOutput({tag, ".mem_addr"},  mem_addr_o,       v.x_mem_addr);
    checkOutput({tag, ".mem_wdata"}, mem_wdata_o,      v.x_mem_wdata);
    checkOutput({tag, ".busy"},      32'(busy_o),      32'(v.x_busy));
    checkOutput({tag, ".err"},       32'(err_o),       32'(v.x_err));
  endtask

  task automatic doReset();
    applyStimulus(zeroVec());
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Directed vectors, one clock cycle each, then hand sequences, then random traffic
  initial begin
    vec_t tbl[26];
    vec_t v;
    int   nGrant;
    logic expIf;
    logic ifPend, dmPend, dmWe;
    logic [31:0] ifAddr, dmAddr, dmWdata;
    logic [3:0]  dmBe;
    logic mBusy, mAccepted, mOwnDm, mKilled, mWe;
    logic [31:0] mAddr, mWdata, respData;
    logic [3:0]  mBe;
    int   mStreak, mAge;
    logic gIf, gDm, killNow, done, timeoutNow;

    // Columns: if_req if_addr if_kill | dm_req we be addr wdata | mem_gnt rvalid rdata |
    //          exp if_gnt rvalid rdata | dm_gnt rvalid rdata | mem_req we be addr wdata | busy err
    // IF-only fetch with zero-wait memory
    tbl[0]  = '{Y, 32'h100, N, N, N, B0, Z32, Z32, Y, N, Z32,          Y, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       N, N};
    tbl[1]  = '{N, Z32, N, N, N, B0, Z32, Z32, Y, N, Z32,              N, N, Z32,          N, N, Z32,          Y, N, BF, 32'h100, Z32,                   Y, N};
    tbl[2]  = '{N, Z32, N, N, N, B0, Z32, Z32, Y, Y, 32'h13,           N, Y, 32'h13,       N, N, Z32,          N, N, B0, Z32, Z32,                       Y, N};
    tbl[3]  = '{N, Z32, N, N, N, B0, Z32, Z32, Y, N, Z32,              N, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       N, N};
    // Store with memory grant delayed three cycles
    tbl[4]  = '{N, Z32, N, Y, Y, 4'h3, 32'h2000, 32'hCAFEF00D, N, N, Z32, N, N, Z32,       Y, N, Z32,          N, N, B0, Z32, Z32,                       N, N};
    tbl[5]  = '{N, Z32, N, N, N, B0, Z32, Z32, N, N, Z32,              N, N, Z32,          N, N, Z32,          Y, Y, 4'h3, 32'h2000, 32'hCAFEF00D,       Y, N};
    tbl[6]  = '{N, Z32, N, N, N, B0, Z32, Z32, N, N, Z32,              N, N, Z32,          N, N, Z32,          Y, Y, 4'h3, 32'h2000, 32'hCAFEF00D,       Y, N};
    tbl[7]  = '{N, Z32, N, N, N, B0, Z32, Z32, Y, N, Z32,              N, N, Z32,          N, N, Z32,          Y, Y, 4'h3, 32'h2000, 32'hCAFEF00D,       Y, N};
    tbl[8]  = '{N, Z32, N, N, N, B0, Z32, Z32, N, N, Z32,              N, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       Y, N};
    tbl[9]  = '{N, Z32, N, N, N, B0, Z32, Z32, N, Y, 32'h12345678,     N, N, Z32,          N, Y, 32'h12345678, N, N, B0, Z32, Z32,                       Y, N};
    // Stray rvalid in IDLE is ignored
    tbl[10] = '{N, Z32, N, N, N, B0, Z32, Z32, N, Y, 32'hFFFF0000,     N, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       N, N};
    // Kill in IDLE alongside a grant has no effect; stray rvalid in REQ ignored
    tbl[11] = '{Y, 32'h200, Y, N, N, B0, Z32, Z32, Y, N, Z32,          Y, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       N, N};
    tbl[12] = '{N, Z32, N, N, N, B0, Z32, Z32, Y, Y, 32'h77,           N, N, Z32,          N, N, Z32,          Y, N, BF, 32'h200, Z32,                   Y, N};
    tbl[13] = '{N, Z32, N, N, N, B0, Z32, Z32, N, N, Z32,              N, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       Y, N};
    tbl[14] = '{N, Z32, N, N, N, B0, Z32, Z32, N, Y, 32'h99,           N, Y, 32'h99,       N, N, Z32,          N, N, B0, Z32, Z32,                       Y, N};
    // Kill in WAIT swallows the response
    tbl[15] = '{Y, 32'h300, N, N, N, B0, Z32, Z32, Y, N, Z32,          Y, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       N, N};
    tbl[16] = '{N, Z32, N, N, N, B0, Z32, Z32, Y, N, Z32,              N, N, Z32,          N, N, Z32,          Y, N, BF, 32'h300, Z32,                   Y, N};
    tbl[17] = '{N, Z32, Y, N, N, B0, Z32, Z32, N, N, Z32,              N, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       Y, N};
    tbl[18] = '{N, Z32, N, N, N, B0, Z32, Z32, N, Y, 32'hABCD,         N, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       Y, N};
    // Next fetch proceeds and is delivered (kill flag cleared)
    tbl[19] = '{Y, 32'h400, N, N, N, B0, Z32, Z32, Y, N, Z32,          Y, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       N, N};
    tbl[20] = '{N, Z32, N, N, N, B0, Z32, Z32, Y, N, Z32,              N, N, Z32,          N, N, Z32,          Y, N, BF, 32'h400, Z32,                   Y, N};
    tbl[21] = '{N, Z32, N, N, N, B0, Z32, Z32, N, Y, 32'hABCD0400,     N, Y, 32'hABCD0400, N, N, Z32,          N, N, B0, Z32, Z32,                       Y, N};
    // Kill in the same cycle as the response
    tbl[22] = '{Y, 32'h500, N, N, N, B0, Z32, Z32, Y, N, Z32,          Y, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       N, N};
    tbl[23] = '{N, Z32, N, N, N, B0, Z32, Z32, Y, N, Z32,              N, N, Z32,          N, N, Z32,          Y, N, BF, 32'h500, Z32,                   Y, N};
    tbl[24] = '{N, Z32, Y, N, N, B0, Z32, Z32, N, Y, 32'h55,           N, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       Y, N};
    tbl[25] = '{N, Z32, N, N, N, B0, Z32, Z32, N, N, Z32,              N, N, Z32,          N, N, Z32,          N, N, B0, Z32, Z32,                       N, N};

    applyStimulus(zeroVec());
    #1;
    checkVec(zeroVec(), "reset");
    doReset();

    for (int i = 0; i < 26; i++) begin
      @(negedge clk_i);
      applyStimulus(tbl[i]);
      #1;
      checkVec(tbl[i], $sformatf("vec%0d", i));
    end

    // Both ports request continuously: every (STARVE_MAX+1)-th grant goes to IF
    doReset();
    v = zeroVec();
    v.if_req = Y; v.if_addr = 32'h500; v.dm_req = Y; v.dm_addr = 32'h600;
    v.mem_gnt = Y; v.mem_rvalid = Y; v.mem_rdata = 32'h1;
    nGrant = 0;
    for (int c = 0; c < 60 && nGrant < 10; c++) begin
      @(negedge clk_i);
      applyStimulus(v);
      #1;
      if (if_gnt_o || dm_gnt_o) begin
        expIf = ((nGrant % (STARVE_MAX + 1)) == STARVE_MAX);
        checkOutput($sformatf("starve.grant%0d.if", nGrant), 32'(if_gnt_o), 32'(expIf));
        checkOutput($sformatf("starve.grant%0d.dm", nGrant), 32'(dm_gnt_o), 32'(!expIf));
        nGrant++;
      end
    end
    checkOutput("starve.grant_count", 32'(nGrant), 32'd10);

    // Reset asserted in WAIT, then a late rvalid after release produces nothing
    doReset();
    @(negedge clk_i);
    v = zeroVec(); v.dm_req = Y; v.dm_addr = 32'h700; v.mem_gnt = Y;
    applyStimulus(v);
    #1;
    checkOutput("rstwait.dm_gnt", 32'(dm_gnt_o), 32'd1);
    @(negedge clk_i);
    v = zeroVec(); v.mem_gnt = Y;
    applyStimulus(v);
    @(negedge clk_i);
    applyStimulus(zeroVec());
    #1;
    checkOutput("rstwait.busy_before", 32'(busy_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    checkVec(zeroVec(), "rstwait.in_reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    v = zeroVec(); v.mem_rvalid = Y; v.mem_rdata = 32'h1111;
    applyStimulus(v);
    #1;
    checkVec(v, "rstwait.after");

`ifdef MEM_TIMEOUT_EN
    // Memory never grants a DM load: abort after TIMEOUT_CYC cycles in REQ
    doReset();
    @(negedge clk_i);
    v = zeroVec(); v.dm_req = Y; v.dm_addr = 32'h800;
    applyStimulus(v);
    #1;
    checkOutput("timeout.dm_gnt", 32'(dm_gnt_o), 32'd1);
    applyStimulus(zeroVec());
    for (int c = 1; c <= int'(TIMEOUT_CYC); c++) begin
      @(negedge clk_i);
      #1;
      checkOutput($sformatf("timeout.err.c%0d", c), 32'(err_o), 32'(c == int'(TIMEOUT_CYC)));
      checkOutput($sformatf("timeout.dm_rvalid.c%0d", c), 32'(dm_rvalid_o), 32'(c == int'(TIMEOUT_CYC)));
    end
    checkOutput("timeout.dm_rdata", dm_rdata_o, 32'hDEADBEEF);
    @(negedge clk_i);
    #1;
    checkOutput("timeout.busy_after", 32'(busy_o), 32'd0);
`endif

    // Random traffic against a transaction-level model of the arbiter
    doReset();
    ifPend = 0; dmPend = 0; ifAddr = 0; dmAddr = 0; dmWdata = 0; dmWe = 0; dmBe = 0;
    mBusy = 0; mAccepted = 0; mOwnDm = 0; mKilled = 0; mWe = 0;
    mAddr = 0; mWdata = 0; mBe = 0; mStreak = 0; mAge = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      if (!ifPend && $urandom_range(0, 1) == 1) begin
        ifPend = 1; ifAddr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dmPend && $urandom_range(0, 1) == 1) begin
        dmPend = 1; dmAddr = $urandom; dmWdata = $urandom;
        dmWe = 1'($urandom_range(0, 1)); dmBe = 4'($urandom);
      end
      v = zeroVec();
      v.if_req = ifPend; v.if_addr = ifAddr; v.if_kill = ($urandom_range(0, 7) == 0);
      v.dm_req = dmPend; v.dm_we = dmWe; v.dm_be = dmBe; v.dm_addr = dmAddr; v.dm_wdata = dmWdata;
      v.mem_gnt = ($urandom_range(0, 3) != 0);
      v.mem_rvalid = ($urandom_range(0, 2) == 0);
      v.mem_rdata = $urandom;

      if (!mBusy) begin
        gIf = v.if_req && (!v.dm_req || mStreak >= int'(STARVE_MAX));
        gDm = v.dm_req && !gIf;
        v.x_if_gnt = gIf;
        v.x_dm_gnt = gDm;
        if (gIf) begin
          mBusy = 1; mOwnDm = 0; mAddr = v.if_addr; mWe = 0; mBe = 4'hF; mWdata = 0; mStreak = 0;
        end else if (gDm) begin
          mBusy = 1; mOwnDm = 1; mAddr = v.dm_addr; mWe = v.dm_we; mBe = v.dm_be; mWdata = v.dm_wdata;
          mStreak = v.if_req ? ((mStreak + 1 > int'(STARVE_MAX)) ? int'(STARVE_MAX) : mStreak + 1) : 0;
        end
        mAccepted = 0; mKilled = 0; mAge = 0;
      end else begin
        v.x_busy = 1;
        killNow = !mOwnDm && v.if_kill;
        done = 0;
        respData = v.mem_rdata;
`ifdef MEM_TIMEOUT_EN
        timeoutNow = (mAge == int'(TIMEOUT_CYC) - 1) && !(mAccepted && v.mem_rvalid);
`else
        timeoutNow = 0;
`endif
        if (!mAccepted) begin
          v.x_mem_req = 1; v.x_mem_we = mWe; v.x_mem_be = mBe; v.x_mem_addr = mAddr; v.x_mem_wdata = mWdata;
        end
        if (timeoutNow) begin
          done = 1; respData = 32'hDEADBEEF; v.x_err = 1;
        end else if (!mAccepted) begin
          if (v.mem_gnt) mAccepted = 1;
        end else if (v.mem_rvalid) begin
          done = 1;
        end
        if (done) begin
          if (mOwnDm) begin
            v.x_dm_rvalid = 1; v.x_dm_rdata = respData;
          end else if (!mKilled && !killNow) begin
            v.x_if_rvalid = 1; v.x_if_rdata = respData;
          end
          mBusy = 0;
        end
        mKilled = mKilled || killNow;
        mAge++;
      end

      applyStimulus(v);
      #1;
      checkVec(v, $sformatf("rnd%0d", cyc));
      if (v.x_if_gnt) ifPend = 0;
      if (v.x_dm_gnt) dmPend = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
